// File: rtl/dual_port_ram_clear_if.sv
// Write/read/clear bundle of the self-clearing dual-port RAM.
// RAM_BYTE_WRITE_EN adds writeByteEnable.
interface dual_port_ram_clear_if #(
    parameter int blockLength     = 32,
    parameter int addressBitWidth = 10
);
    logic                       clearStart;
    logic                       busy;
    logic                       writeEnable;
    logic [addressBitWidth-1:0] writeAddress;
    logic [blockLength-1:0]     writeData;
`ifdef RAM_BYTE_WRITE_EN
    logic [blockLength/8-1:0]   writeByteEnable;
`endif
    logic                       readEnable;
    logic [addressBitWidth-1:0] readAddress;
    logic                       readValid;
    logic [blockLength-1:0]     dataOut;

    modport master (
`ifdef RAM_BYTE_WRITE_EN
        output writeByteEnable,
`endif
        output clearStart,
        output writeEnable,
        output writeAddress,
        output writeData,
        output readEnable,
        output readAddress,
        input  busy,
        input  readValid,
        input  dataOut
    );

    modport slave (
`ifdef RAM_BYTE_WRITE_EN
        input  writeByteEnable,
`endif
        input  clearStart,
        input  writeEnable,
        input  writeAddress,
        input  writeData,
        input  readEnable,
        input  readAddress,
        output busy,
        output readValid,
        output dataOut
    );
endinterface

// File: rtl/dual_port_ram_clear.sv
// Dual-port RAM with a clear sweep after reset or on request.
// RAM_BYTE_WRITE_EN enables per-byte write strobes.
module dual_port_ram_clear #(
    parameter int                     blockLength     = 32,
    parameter int                     memDepth        = 1024,
    parameter int                     addressBitWidth = 10,
    parameter logic [blockLength-1:0] CLEAR_VALUE     = '0,
    parameter int                     READ_LATENCY    = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    dual_port_ram_clear_if.slave  bus
);

    localparam int IW = (memDepth > 1) ? $clog2(memDepth) : 1;
    localparam logic [addressBitWidth:0] DEPTH =
        (addressBitWidth + 1)'(memDepth);
    localparam logic [addressBitWidth-1:0] LAST =
        addressBitWidth'(memDepth - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t                     state;
    state_t                     stateNext;
    logic [addressBitWidth-1:0] clearCount;
    logic [addressBitWidth-1:0] clearCountNext;
    logic [blockLength-1:0]     ram [memDepth];
    logic                       busy;
    logic                       wrHit;
    logic                       rdHit;
    logic                       rdInRange;
    logic                       rd1Valid;
    logic [blockLength-1:0]     rd1Data;

    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("READ_LATENCY must be 1 or 2");
    end

`ifdef RAM_BYTE_WRITE_EN
    if (blockLength % 8 != 0) begin : g_bad_width
        $error("blockLength must be a multiple of 8 for byte writes");
    end
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= CLEAR;
            clearCount <= '0;
        end else begin
            state      <= stateNext;
            clearCount <= clearCountNext;
        end
    end

    always_comb begin
        stateNext      = state;
        clearCountNext = clearCount;
        unique case (state)
            CLEAR: begin
                if (clearCount == LAST) begin
                    stateNext      = IDLE;
                    clearCountNext = '0;
                end else begin
                    clearCountNext = clearCount + 1'b1;
                end
            end
            IDLE: begin
                if (bus.clearStart) begin
                    stateNext      = CLEAR;
                    clearCountNext = '0;
                end
            end
        endcase
    end

    assign busy      = (state == CLEAR);
    assign bus.busy  = busy;
    assign wrHit     = !busy && bus.writeEnable &&
                       ({1'b0, bus.writeAddress} < DEPTH);
    assign rdHit     = !busy && bus.readEnable;
    assign rdInRange = ({1'b0, bus.readAddress} < DEPTH);

    // Sweep owns the write port; user writes only land when idle.
    always_ff @(posedge clock) begin
        if (busy) begin
            ram[clearCount[IW-1:0]] <= CLEAR_VALUE;
        end else if (wrHit) begin
`ifdef RAM_BYTE_WRITE_EN
            for (int i = 0; i < blockLength / 8; i++) begin
                if (bus.writeByteEnable[i]) begin
                    ram[bus.writeAddress[IW-1:0]][i*8 +: 8] <=
                        bus.writeData[i*8 +: 8];
                end
            end
`else
            ram[bus.writeAddress[IW-1:0]] <= bus.writeData;
`endif
        end
    end

    // Non-blocking read of the array gives read-first behaviour.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd1Valid <= 1'b0;
            rd1Data  <= '0;
        end else begin
            rd1Valid <= rdHit;
            if (rdHit) begin
                rd1Data <= rdInRange ? ram[bus.readAddress[IW-1:0]]
                                     : CLEAR_VALUE;
            end
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic                   rd2Valid;
        logic [blockLength-1:0] rd2Data;

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                rd2Valid <= 1'b0;
                rd2Data  <= '0;
            end else begin
                rd2Valid <= rd1Valid;
                if (rd1Valid) begin
                    rd2Data <= rd1Data;
                end
            end
        end

        assign bus.readValid = rd2Valid;
        assign bus.dataOut   = rd2Data;
    end else begin : g_lat1
        assign bus.readValid = rd1Valid;
        assign bus.dataOut   = rd1Data;
    end

endmodule

// File: tb/tb_dual_port_ram_clear.sv
// Randomised bench for dual_port_ram_clear, latency 1 and 2 side by side.
// Reference model: word array plus remaining-sweep counter.
module tb_dual_port_ram_clear;

    localparam int          BL = 32;
    localparam int          MD = 16;
    localparam int          AW = 5;
    localparam logic [31:0] CV = 32'hDEADBEEF;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic          cs, we, re;
    logic [AW-1:0] wa, ra;
    logic [31:0]   wd;
    logic [3:0]    wbe;

    dual_port_ram_clear_if #(.blockLength(BL), .addressBitWidth(AW)) bus1 ();
    dual_port_ram_clear_if #(.blockLength(BL), .addressBitWidth(AW)) bus2 ();

    assign bus1.clearStart   = cs;
    assign bus1.writeEnable  = we;
    assign bus1.writeAddress = wa;
    assign bus1.writeData    = wd;
    assign bus1.readEnable   = re;
    assign bus1.readAddress  = ra;
    assign bus2.clearStart   = cs;
    assign bus2.writeEnable  = we;
    assign bus2.writeAddress = wa;
    assign bus2.writeData    = wd;
    assign bus2.readEnable   = re;
    assign bus2.readAddress  = ra;
`ifdef RAM_BYTE_WRITE_EN
    assign bus1.writeByteEnable = wbe;
    assign bus2.writeByteEnable = wbe;
`endif

    dual_port_ram_clear #(
        .blockLength(BL), .memDepth(MD), .addressBitWidth(AW),
        .CLEAR_VALUE(CV), .READ_LATENCY(1)
    ) dut1 (
        .clock(clock), .reset(reset), .bus(bus1.slave)
    );

    dual_port_ram_clear #(
        .blockLength(BL), .memDepth(MD), .addressBitWidth(AW),
        .CLEAR_VALUE(CV), .READ_LATENCY(2)
    ) dut2 (
        .clock(clock), .reset(reset), .bus(bus2.slave)
    );

    logic [31:0] mem [MD];
    int          clearLeft;
    logic        ev1, ev2;
    logic [31:0] ed1, ed2;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[i*8 +: 8] = nw[i*8 +: 8];
        end
        return r;
    endfunction

    task automatic model_reset();
        clearLeft = MD;
        ev1 = 1'b0;
        ev2 = 1'b0;
        ed1 = '0;
        ed2 = '0;
    endtask

    task automatic check_outs(input string tag);
        chk({tag, "_busy1"}, {31'd0, bus1.busy}, {31'd0, clearLeft > 0});
        chk({tag, "_busy2"}, {31'd0, bus2.busy}, {31'd0, clearLeft > 0});
        chk({tag, "_rv1"}, {31'd0, bus1.readValid}, {31'd0, ev1});
        chk({tag, "_rv2"}, {31'd0, bus2.readValid}, {31'd0, ev2});
        chk({tag, "_do1"}, bus1.dataOut, ed1);
        chk({tag, "_do2"}, bus2.dataOut, ed2);
    endtask

    task automatic cycle(input string tag);
        logic idle;
        @(posedge clock);
        if (!reset) begin
            model_reset();
        end else begin
            idle = (clearLeft == 0);
            if (ev1) ed2 = ed1;
            ev2 = ev1;
            ev1 = idle && re;
            if (ev1) ed1 = (ra < MD) ? mem[ra[3:0]] : CV;
            if (idle && we && wa < MD) mem[wa[3:0]] = merge(mem[wa[3:0]], wd, wbe);
            if (!idle) begin
                mem[MD - clearLeft] = CV;
                clearLeft--;
            end else if (cs) begin
                clearLeft = MD;
            end
        end
        #1;
        check_outs(tag);
    endtask

    task automatic drive(input logic c, input logic w, input logic [AW-1:0] a,
                         input logic [31:0] d, input logic r,
                         input logic [AW-1:0] b);
        cs = c; we = w; wa = a; wd = d; re = r; ra = b;
    endtask

    initial begin
        drive(0, 0, '0, '0, 0, '0);
        wbe = 4'hF;
        for (int i = 0; i < MD; i++) mem[i] = CV;
        model_reset();

        repeat (3) cycle("rst");
        #2 reset = 1'b1;
        #1 check_outs("rel");
        repeat (MD) cycle("sweep");

        for (int i = 0; i < MD + 2; i++) begin
            drive(0, 0, '0, '0, 1, AW'(i));
            cycle("rdall");
        end
        drive(0, 0, '0, '0, 0, '0);
        repeat (2) cycle("idle");

        drive(0, 1, 5'd5, 32'h12345678, 0, '0);
        cycle("wr5");
        drive(0, 0, '0, '0, 1, 5'd5);
        cycle("rd5a");
        ra = 5'd4;
        cycle("rd4");
        ra = 5'd5;
        cycle("rd5b");
        chk("b2b_l1", bus1.dataOut, 32'h12345678);
        drive(0, 0, '0, '0, 0, '0);
        cycle("b2b_t");
        chk("b2b_l2", bus2.dataOut, 32'h12345678);
        cycle("idle");

        drive(0, 1, 5'd3, 32'hAAAA0000, 1, 5'd3);
        cycle("rdw");
        chk("rdw_old", bus1.dataOut, CV);
        drive(0, 0, '0, '0, 1, 5'd3);
        cycle("rdw_new");
        chk("rdw_new_v", bus1.dataOut, 32'hAAAA0000);
        drive(0, 0, '0, '0, 0, '0);
        repeat (2) cycle("idle");

        drive(0, 1, 5'd7, 32'h55, 0, '0);
        cycle("wr7");
        drive(1, 1, 5'd8, 32'h99, 1, 5'd7);
        cycle("cs");
        drive(0, 0, '0, '0, 0, '0);
        for (int i = 0; i < MD; i++) begin
            drive($urandom_range(0, 1), 1, AW'($urandom_range(0, 15)),
                  $urandom, 1, AW'($urandom_range(0, 15)));
            cycle("busyio");
        end
        drive(0, 0, '0, '0, 1, 5'd7);
        cycle("rd7");
        chk("rd7_cv", bus1.dataOut, CV);
        drive(0, 0, '0, '0, 0, '0);
        repeat (2) cycle("idle");

        drive(1, 0, '0, '0, 0, '0);
        cycle("cs2");
        drive(0, 0, '0, '0, 0, '0);
        repeat (8) cycle("half");
        drive(0, 1, 5'd1, 32'h77, 1, 5'd1);
        reset = 1'b0;
        model_reset();
        #1 check_outs("rstmid");
        repeat (2) cycle("rstmid");
        drive(0, 0, '0, '0, 0, '0);
        reset = 1'b1;
        repeat (MD) cycle("resweep");

`ifdef RAM_BYTE_WRITE_EN
        drive(0, 1, 5'd2, 32'hFFFFFFFF, 0, '0);
        cycle("bw1");
        drive(0, 1, 5'd2, 32'h11223344, 0, '0);
        wbe = 4'b0101;
        cycle("bw2");
        wbe = 4'hF;
        drive(0, 0, '0, '0, 1, 5'd2);
        cycle("bwrd");
        chk("bw_val", bus1.dataOut, 32'hFF22FF44);
        drive(0, 0, '0, '0, 0, '0);
`endif

        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 39) == 0, $urandom_range(0, 1),
                  AW'($urandom_range(0, 19)), $urandom,
                  $urandom_range(0, 1), AW'($urandom_range(0, 19)));
`ifdef RAM_BYTE_WRITE_EN
            wbe = 4'($urandom);
`endif
            cycle("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
